// File: rtl/ram32x4_loader_if.sv
// Load-stream and read-port bundle for ram32x4_loader.
// The master side sources nibbles and issues read addresses.
interface ram32x4_loader_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 4
);
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  modport master (
    output din, din_valid, rd_addr,
    input  din_ready, rd_data
  );

  modport slave (
    input  din, din_valid, rd_addr,
    output din_ready, rd_data
  );
endinterface

// File: rtl/ram32x4_loader.sv
// 32x4 RAM with a sequential load controller and a ROM-compatible registered read port.
// Loads start at address 0; a load ends on stop or after the last word.
module ram32x4_loader #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  ram32x4_loader_if.slave  bus,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      count
);

  localparam int unsigned     Depth   = 2 ** AW;
  localparam logic [AW-1:0]   LastA   = AW'(Depth - 1);
  localparam logic [AW-1:0]   AddrOne = AW'(1);
  localparam logic [AW:0]     CntOne  = (AW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] mem [Depth];

  logic accept;
  logic last_word;

  assign accept    = bus.din_valid & (state_q == StLoad);
  assign last_word = accept & (wr_addr_q == LastA);

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      wr_addr_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    count_d   = count_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StLoad;
          wr_addr_d = '0;
          count_d   = '0;
        end
      end
      StLoad: begin
        // The accepted word is counted even when stop ends the load in the same cycle.
        if (accept) begin
          wr_addr_d = wr_addr_q + AddrOne;
          count_d   = count_q + CntOne;
        end
        if (stop || last_word) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    busy          = (state_q == StLoad);
    done          = (state_q == StDone);
    bus.din_ready = (state_q == StLoad);
    count         = count_q;
    bus.rd_data   = rd_data_q;
  end

  // Storage is not reset; writes are suppressed while rstn is low.
  always_ff @(posedge clk) begin
    if (rstn && accept) begin
      mem[wr_addr_q] <= bus.din;
    end
  end

  // Read-before-write: a same-address write shows up one cycle later.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[bus.rd_addr];
    end
  end

endmodule

// File: tb/tb_ram32x4_loader.sv
// Directed bench for ram32x4_loader: load, gaps, early stop, read-during-write,
// reset mid-load, reload and ignored input.
module tb_ram32x4_loader;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       stop;
  logic       busy;
  logic       done;
  logic [5:0] count;

  int total;
  int bad;
  int wptr;
  logic [3:0] model [32];

  ram32x4_loader_if #(.AW(5), .DW(4)) bus ();

  ram32x4_loader #(.AW(5), .DW(4)) u_dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .stop  (stop),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted word, valid dropped afterwards
  task automatic push(input logic [3:0] d);
    bus.din_valid = 1'b1;
    bus.din       = d;
    tick();
    bus.din_valid = 1'b0;
    model[wptr]   = d;
    wptr++;
  endtask

  task automatic rd_check(input string tag, input int k, input logic [3:0] exp);
    bus.rd_addr = 5'(k);
    tick();
    chk(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    wptr  = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    wptr  = 0;
    rstn  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.rd_addr   = '0;
    tick();
    tick();
    rstn = 1'b1;

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(bus.din_ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);

    // 1: full load with valid held high
    do_start();
    chk("t1_busy_load", 32'(busy), 32'd1);
    chk("t1_ready_load", 32'(bus.din_ready), 32'd1);
    chk("t1_count0", 32'(count), 32'd0);
    bus.din_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.din  = 4'(i);
      model[i] = 4'(i);
      tick();
    end
    bus.din_valid = 1'b0;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_count", 32'(count), 32'd32);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_ready", 32'(bus.din_ready), 32'd0);
    for (int k = 0; k < 32; k++) begin
      rd_check("t1_rd", k, 4'(k % 16));
    end

    // 2: gappy source, then stop
    do_start();
    for (int j = 0; j < 8; j++) begin
      push(4'(j + 8));
      tick();
      tick();
      if (j == 3) chk("t2_count_mid", 32'(count), 32'd4);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_count", 32'(count), 32'd8);
    for (int k = 0; k < 8; k++) begin
      rd_check("t2_rd", k, 4'(k + 8));
    end
    rd_check("t2_rd_addr8", 8, 4'h8);

    // 3: early stop with a same-cycle accept; start during LOAD ignored
    do_start();
    push(4'h9);
    push(4'hB);
    push(4'hD);
    start = 1'b1;
    push(4'hC);
    start = 1'b0;
    chk("t3_count_start_ignored", 32'(count), 32'd4);
    chk("t3_busy", 32'(busy), 32'd1);
    stop          = 1'b1;
    bus.din_valid = 1'b1;
    bus.din       = 4'hA;
    tick();
    stop          = 1'b0;
    bus.din_valid = 1'b0;
    model[4]      = 4'hA;
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_count", 32'(count), 32'd5);
    rd_check("t3_rd_addr4", 4, 4'hA);
    rd_check("t3_rd_addr3", 3, 4'hC);

    // 5: read-during-write at address 3 (old 0xC, new 0x5)
    do_start();
    push(4'h1);
    push(4'h2);
    push(4'h3);
    bus.rd_addr   = 5'd3;
    bus.din_valid = 1'b1;
    bus.din       = 4'h5;
    tick();
    bus.din_valid = 1'b0;
    model[3]      = 4'h5;
    wptr          = 4;
    chk("t5_rd_old", 32'(bus.rd_data), 32'hC);
    chk("t5_count", 32'(count), 32'd4);
    tick();
    chk("t5_rd_new", 32'(bus.rd_data), 32'h5);

    // 4: reset mid-load at count=10
    for (int j = 0; j < 6; j++) begin
      push(4'(j + 6));
    end
    chk("t4_count10", 32'(count), 32'd10);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_ready", 32'(bus.din_ready), 32'd0);
    chk("t4_count", 32'(count), 32'd0);
    for (int k = 0; k < 10; k++) begin
      rd_check("t4_rd", k, model[k]);
    end

    // 6b: din_valid in IDLE writes nothing
    bus.din_valid = 1'b1;
    bus.din       = 4'hE;
    tick();
    tick();
    bus.din_valid = 1'b0;
    chk("t6_idle_count", 32'(count), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    rd_check("t6_idle_rd0", 0, model[0]);

    // 6: reach DONE with an empty load, then reload one word
    do_start();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_empty_done", 32'(done), 32'd1);
    chk("t6_empty_count", 32'(count), 32'd0);
    do_start();
    push(4'hF);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_count", 32'(count), 32'd1);
    rd_check("t6_rd0", 0, 4'hF);
    for (int k = 1; k < 32; k++) begin
      rd_check("t6_rd", k, model[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
